// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver clocked from a 16x oversample tick.
// Recovers bytes from the asynchronous serial line. Each byte is delivered on a
// one-deep valid/ready output register. Bad stop bits and dropped bytes are flagged.
//
// Ports:
//   CLK        in   system clock
//   rst_n      in   synchronous active-low reset
//   os_tick    in   one-CLK pulse at OS x baud
//   rx         in   asynchronous serial line, idles high
//   out_data   out  received byte (valid while out_valid=1)
//   out_valid  out  out_data holds an undelivered byte
//   out_ready  in   consumer accepts the byte when out_valid & out_ready
//   frame_err  out  one-CLK pulse on a bad stop bit
//   overrun    out  one-CLK pulse when a completed byte is dropped
//   busy       out  receiver is not idle (combinational from state)
module uart_rx #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned OS        = 16
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 os_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(OS);
   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] CNT_MID  = CW'(OS / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OS - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        os_cnt_q, os_cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] out_data_d;
   logic                 out_valid_d;
   logic                 frame_err_d;
   logic                 overrun_d;
   logic                 rx_m, rx_s;
   logic                 done_c;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         os_cnt_q  <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         os_cnt_q  <= os_cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         frame_err <= frame_err_d;
         overrun   <= overrun_d;
      end
   end

   // Next-state, frame sampling and output register delivery
   always_comb begin
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      out_data_d  = out_data;
      out_valid_d = out_valid;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      done_c      = 1'b0;

      if (out_valid && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (os_tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_d  = S_START;
                  os_cnt_d = '0;
               end
            end

            // Re-check the line at mid start bit to reject glitches
            S_START: begin
               if (os_cnt_q == CNT_MID) begin
                  if (!rx_s) begin
                     state_d   = S_DATA;
                     os_cnt_d  = '0;
                     bit_idx_d = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + CW'(1);
               end
            end

            // One full bit period after mid start lands on each bit centre
            S_DATA: begin
               if (os_cnt_q == CNT_END) begin
                  shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
                  os_cnt_d = '0;
                  if (bit_idx_q == IDX_LAST) begin
                     state_d = S_STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + BW'(1);
                  end
               end else begin
                  os_cnt_d = os_cnt_q + CW'(1);
               end
            end

            S_STOP: begin
               if (os_cnt_q == CNT_END) begin
                  os_cnt_d = '0;
                  if (rx_s) begin
                     state_d = S_IDLE;
                     done_c  = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + CW'(1);
               end
            end

            // Wait out a held-low line so it yields a single frame error
            S_BREAK: begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // A completed byte loads if the register is free or being emptied now
      if (done_c) begin
         if (!out_valid || out_ready) begin
            out_data_d  = shreg_q;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized checks of uart_rx.
// Frames are driven at 32 CLK per bit (os_tick every 2nd CLK). Expected bytes
// are kept in a queue and matched against each valid/ready handshake.
module tb_uart_rx;

   localparam int BIT_CYC = 32;

   logic       clk;
   logic       rst_n;
   logic       os_tick;
   logic       rx;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests;
   int fails;
   int fe_cnt;
   int ov_cnt;
   int rise_cnt;
   int busy_drop;
   bit watch_busy;
   bit rand_rdy;
   logic [7:0] exp_q[$];

   uart_rx #(.DATA_BITS(8), .OS(16)) dut (
      .CLK       (clk),
      .rst_n     (rst_n),
      .os_tick   (os_tick),
      .rx        (rx),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CLK: score handshakes, advance, sample outputs, toggle os_tick
   task automatic cyc();
      logic       prev_v;
      logic [7:0] prev_d;
      logic       prev_rst;
      logic       hs;
      logic [7:0] e;
      prev_v   = out_valid;
      prev_d   = out_data;
      prev_rst = rst_n;
      hs       = out_valid && out_ready && rst_n;
      if (hs) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_extra: observed byte %0h expected none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(out_data), 32'(e));
         end
      end
      @(posedge clk);
      #1;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (!prev_v && out_valid) rise_cnt++;
      if (frame_err || overrun) check("flags_exclusive", 32'(frame_err & overrun), 32'(0));
      if (prev_v && !hs && prev_rst) begin
         check("valid_hold", 32'(out_valid), 32'(1));
         check("data_hold", 32'(out_data), 32'(prev_d));
      end
      if (watch_busy && !busy) busy_drop++;
      os_tick = ~os_tick;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Drive one 8N1 frame; optional one-cycle out_ready pulse or reset pulse at a frame cycle
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at,
                             input int rst_at, output int rise_at);
      logic [9:0] bits;
      int         start_rise;
      bits = {stop, b, 1'b0};
      if (!os_tick) cyc();
      start_rise = rise_cnt;
      rise_at    = -1;
      for (int n = 0; n < 10 * BIT_CYC; n++) begin
         if (n % BIT_CYC == 0) rx = bits[n / BIT_CYC];
         cyc();
         if (rise_at < 0 && rise_cnt != start_rise) rise_at = n + 1;
         if (n + 1 == rdy_at) out_ready = 1'b1;
         if (rdy_at >= 0 && n + 1 == rdy_at + 1) out_ready = 1'b0;
         if (n + 1 == rst_at) rst_n = 1'b0;
         if (rst_at >= 0 && n + 1 == rst_at + 1) begin
            rst_n = 1'b1;
            rx    = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      int         r;
      int         fe0, ov0, rs0;
      logic [7:0] b;

      tests = 0; fails = 0; fe_cnt = 0; ov_cnt = 0; rise_cnt = 0;
      busy_drop = 0; watch_busy = 1'b0; rand_rdy = 1'b0;
      rst_n = 1'b0; os_tick = 1'b0; rx = 1'b1; out_ready = 1'b0;

      // Reset state
      idle(3);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      check("rst_frame_err", 32'(frame_err), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
      idle(20);

      // 0xA5 held with out_ready=0, then accepted
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'hA5, 1'b1, -1, -1, r);
      check("a5_latency_ok", 32'(r >= 300 && r <= 312), 32'(1));
      check("a5_valid", 32'(out_valid), 32'(1));
      check("a5_data", 32'(out_data), 32'h A5);
      idle(50);
      check("a5_still_valid", 32'(out_valid), 32'(1));
      exp_q.push_back(8'hA5);
      out_ready = 1'b1;
      cyc();
      check("a5_cleared", 32'(out_valid), 32'(0));
      check("a5_no_fe", 32'(fe_cnt - fe0), 32'(0));
      check("a5_no_ov", 32'(ov_cnt - ov0), 32'(0));

      // Start-bit glitch of 4 os_ticks, then 0x3C
      rs0 = rise_cnt;
      rx = 1'b0;
      idle(8);
      rx = 1'b1;
      idle(40);
      check("glitch_busy", 32'(busy), 32'(0));
      check("glitch_no_valid", 32'(rise_cnt - rs0), 32'(0));
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, -1, -1, r);
      check("3c_delivered", 32'(exp_q.size()), 32'(0));

      // Bad stop bit then line held low for 20 bit periods
      fe0 = fe_cnt; rs0 = rise_cnt;
      send_frame(8'h5A, 1'b0, -1, -1, r);
      watch_busy = 1'b1;
      busy_drop  = 0;
      idle(20 * BIT_CYC);
      watch_busy = 1'b0;
      check("brk_busy_held", 32'(busy_drop), 32'(0));
      check("brk_one_fe", 32'(fe_cnt - fe0), 32'(1));
      check("brk_no_valid", 32'(rise_cnt - rs0), 32'(0));
      rx = 1'b1;
      idle(20);
      check("brk_released", 32'(busy), 32'(0));
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1, -1, -1, r);
      check("01_delivered", 32'(exp_q.size()), 32'(0));

      // Overrun: 0x11 held, 0x22 dropped
      out_ready = 1'b0;
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1, -1, -1, r);
      send_frame(8'h22, 1'b1, -1, -1, r);
      check("ovr_one_pulse", 32'(ov_cnt - ov0), 32'(1));
      check("ovr_valid", 32'(out_valid), 32'(1));
      check("ovr_data_kept", 32'(out_data), 32'h11);
      exp_q.push_back(8'h11);
      out_ready = 1'b1;
      cyc();
      check("ovr_cleared", 32'(out_valid), 32'(0));
      idle(40);
      check("ovr_no_22", 32'(out_valid), 32'(0));

      // Handshake in the same cycle a new byte completes
      out_ready = 1'b0;
      ov0 = ov_cnt;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1, -1, -1, r);
      send_frame(8'h22, 1'b1, 306, -1, r);
      check("same_no_ov", 32'(ov_cnt - ov0), 32'(0));
      check("same_valid", 32'(out_valid), 32'(1));
      check("same_data", 32'(out_data), 32'h22);
      out_ready = 1'b1;
      cyc();
      check("same_cleared", 32'(out_valid), 32'(0));
      check("same_sb_empty", 32'(exp_q.size()), 32'(0));

      // Reset pulse during data bit 3 of 0x77
      fe0 = fe_cnt; ov0 = ov_cnt; rs0 = rise_cnt;
      send_frame(8'h77, 1'b1, -1, 150, r);
      check("midrst_valid", 32'(out_valid), 32'(0));
      check("midrst_data", 32'(out_data), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_fe", 32'(frame_err), 32'(0));
      check("midrst_ov", 32'(overrun), 32'(0));
      idle(40);
      check("midrst_quiet", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (rise_cnt - rs0)), 32'(0));
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, -1, -1, r);
      check("ff_delivered", 32'(exp_q.size()), 32'(0));

      // Random bytes, random gaps, random out_ready
      fe0 = fe_cnt; ov0 = ov_cnt;
      rand_rdy = 1'b1;
      for (int k = 0; k < 12; k++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         idle(int'($urandom_range(0, 40)));
         send_frame(b, 1'b1, -1, -1, r);
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      idle(20);
      check("rand_drained", 32'(exp_q.size()), 32'(0));
      check("rand_no_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
